mem_arbiter: RTL

Two-requester arbiter that shares the single external memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined MIPS core. It sits between both cache controllers and the memory interface. It accepts one block transaction at a time and alternates grants round-robin when both sides request. It holds the granted request stable on the memory bus until memory acknowledges, then returns read data and a one-cycle ready pulse to the winner.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between the I-cache and the D-cache.
// Optional busy-state watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              d_req, grant_d, grant_i, busy, timeout_hit;

  assign d_req = d_read | d_write;
  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter is zero outside BUSY, so every grant starts it from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (busy & ~mem_ready & timeout_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign arb_err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign arb_err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the side that did not win the previous tie is served.
        grant_d = d_req && (!i_read || !last_d_q);
        grant_i = i_read && !grant_d;
        if (i_read && d_req) begin
          last_d_d = grant_d;
        end
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_write_d = d_write;
          mem_read_d  = !d_write;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_addr_d  = i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || timeout_hit) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ready_d = 1'b1;
            if (mem_ready) begin
              i_rdata_d = mem_rdata;
            end
          end else begin
            d_ready_d = 1'b1;
            if (mem_ready && mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule
